down_counter_timer: RTL and testbench

Loadable down-counter/timer, the counting-down counterpart of the team's up counter with terminal count.
- Loads a start value from `data` and decrements once per enabled cycle.
- Pulses `tc` when the count expires.
- Either stops (one-shot) or reloads the start value (auto-reload).
- Used as a programmable interval/timeout generator next to the up counter in the same clock domain.

---
 rtl/down_counter_timer.sv | 133 +++++++++++++
 tb/tb_down_counter_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter / interval timer.
// Loads a start value, decrements once per enabled RUN cycle, pulses tc on
// expiry and then either stops in DONE (one-shot) or reloads (auto-reload).
// Optional prescaler: define DOWN_COUNTER_PRESCALE_EN so that one decrement
// takes PRESCALE enabled cycles instead of one.
module down_counter_timer #(
  parameter int SIZE     = 4,
  parameter int PRESCALE = 4
) (
  input  logic            clk,
  input  logic            r,
  input  logic            e,
  input  logic            ld,
  input  logic            mode,
  input  logic [SIZE-1:0] data,
  output logic [SIZE-1:0] count,
  output logic            tc,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reject out-of-range configurations at elaboration time.
  if (SIZE < 2 || SIZE > 16 || PRESCALE < 2 || PRESCALE > 256) begin : g_bad_param
    $error("down_counter_timer: SIZE must be 2..16 and PRESCALE 2..256");
  end

  state_t          state, state_nxt;
  logic [SIZE-1:0] reload, reload_nxt;
  logic [SIZE-1:0] count_nxt;
  logic            mode_q, mode_nxt;
  logic            tc_nxt;
  logic            tick;

`ifdef DOWN_COUNTER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] prescaler, prescaler_nxt;

  // A decrement is due only on the last enabled cycle of each prescale period.
  assign tick = (prescaler == PW'(PRESCALE - 1));
`else
  // No prescaler: every enabled RUN cycle is a decrement.
  assign tick = 1'b1;
`endif

  // Next-state, next-count and terminal-count decision.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    mode_nxt   = mode_q;
    tc_nxt     = 1'b0;
`ifdef DOWN_COUNTER_PRESCALE_EN
    prescaler_nxt = prescaler;
`endif

    if (ld) begin
      reload_nxt = data;
      mode_nxt   = mode;
`ifdef DOWN_COUNTER_PRESCALE_EN
      prescaler_nxt = '0;
`endif
      if (data != '0) begin
        count_nxt = data;
        state_nxt = RUN;
      end else begin
        count_nxt = '0;
        state_nxt = IDLE;
      end
    end else if (state == RUN && e) begin
`ifdef DOWN_COUNTER_PRESCALE_EN
      prescaler_nxt = tick ? '0 : prescaler + PW'(1);
`endif
      if (tick) begin
        if (count == SIZE'(1)) begin
          tc_nxt = 1'b1;
          if (mode_q) begin
            count_nxt = reload;
          end else begin
            count_nxt = '0;
            state_nxt = DONE;
          end
        end else begin
          count_nxt = count - SIZE'(1);
        end
      end
    end
  end

  // State and datapath registers; busy/done are registered decodes of the
  // next state so they change exactly with the state and never glitch.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      mode_q <= 1'b0;
      tc     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      mode_q <= mode_nxt;
      tc     <= tc_nxt;
      busy   <= (state_nxt == RUN);
      done   <= (state_nxt == DONE);
    end
  end

`ifdef DOWN_COUNTER_PRESCALE_EN
  // Prescaler register, cleared by reset and by load.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: self-checking bench for down_counter_timer.
// A behavioural model tracks enabled cycles since load/reload and derives the
// expected outputs arithmetically; it is compared every cycle, and literal
// expectations from hand-worked sequences pin the model itself.
module tb_down_counter_timer;

  localparam int SIZE     = 4;
  localparam int PRESCALE = 4;
`ifdef DOWN_COUNTER_PRESCALE_EN
  localparam int P = PRESCALE;
`else
  localparam int P = 1;
`endif

  logic            clk = 1'b0;
  logic            r;
  logic            e;
  logic            ld;
  logic            mode;
  logic [SIZE-1:0] data;
  logic [SIZE-1:0] count;
  logic            tc;
  logic            busy;
  logic            done;

  int n_tests = 0;
  int n_fail  = 0;

  down_counter_timer #(.SIZE(SIZE), .PRESCALE(PRESCALE)) dut (
    .clk  (clk),
    .r    (r),
    .e    (e),
    .ld   (ld),
    .mode (mode),
    .data (data),
    .count(count),
    .tc   (tc),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a running timer loaded with N counts k enabled cycles; it
  // expires when k reaches N*P, and shows N - floor(k/P) while running.
  bit m_run  = 1'b0;
  bit m_done = 1'b0;
  bit m_mode = 1'b0;
  bit m_tc   = 1'b0;
  int m_n    = 0;
  int m_k    = 0;

  always @(posedge clk or posedge r) begin
    if (r) begin
      m_run = 1'b0; m_done = 1'b0; m_mode = 1'b0; m_tc = 1'b0; m_n = 0; m_k = 0;
    end else if (ld) begin
      m_n = int'(data); m_mode = mode; m_k = 0; m_tc = 1'b0; m_done = 1'b0;
      m_run = (data != '0);
    end else begin
      m_tc = 1'b0;
      if (m_run && e) begin
        m_k++;
        if (m_k == m_n * P) begin
          m_tc = 1'b1;
          if (m_mode) m_k = 0;
          else begin
            m_run  = 1'b0;
            m_done = 1'b1;
          end
        end
      end
    end
  end

  function automatic int exp_count();
    return m_run ? (m_n - m_k / P) : 0;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (r === 1'b0) begin
      check("cmp_count", 32'(count), 32'(exp_count()));
      check("cmp_tc",    32'(tc),    32'(m_tc));
      check("cmp_busy",  32'(busy),  32'(m_run));
      check("cmp_done",  32'(done),  32'(m_done));
    end
  end

  // One clock of stimulus; returns 1 ns after the edge with outputs settled.
  task automatic cyc(input logic ei, input logic li, input logic mi, input logic [SIZE-1:0] di);
    e = ei; ld = li; mode = mi; data = di;
    @(posedge clk);
    #1;
  endtask

  initial begin
    r = 1'b1; e = 1'b0; ld = 1'b0; mode = 1'b0; data = '0;
    repeat (2) @(posedge clk);
    #1 r = 1'b0;
    check("reset_count", 32'(count), 0);
    check("reset_flags", {29'd0, tc, busy, done}, 0);

`ifndef DOWN_COUNTER_PRESCALE_EN
    // Reset mid-run: asynchronous clear before the next edge.
    cyc(0, 1, 0, 4'd5);
    cyc(1, 0, 0, 4'd0);
    cyc(1, 0, 0, 4'd0);
    check("t1_count_pre", 32'(count), 3);
    #1 r = 1'b1;
    #1;
    check("t1_async_count", 32'(count), 0);
    check("t1_async_flags", {29'd0, tc, busy, done}, 0);
    r = 1'b0;
    cyc(1, 0, 0, 4'd0);
    cyc(1, 0, 0, 4'd0);
    check("t1_idle_count", 32'(count), 0);

    // One-shot 3,2,1,0 then stays.
    cyc(0, 1, 0, 4'd3);
    check("t2_load", 32'(count), 3);
    check("t2_busy", 32'(busy), 1);
    cyc(1, 0, 0, 4'd0);
    cyc(1, 0, 0, 4'd0);
    check("t2_count1", 32'(count), 1);
    check("t2_tc_early", 32'(tc), 0);
    cyc(1, 0, 0, 4'd0);
    check("t2_expire", {28'd0, count}, 0);
    check("t2_flags", {29'd0, tc, busy, done}, 32'b101);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 4'd0);
    check("t2_hold", {27'd0, count, tc}, 0);
    check("t2_done_hold", 32'(done), 1);

    // Auto-reload period 2.
    cyc(0, 1, 1, 4'd2);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 0, 4'd0);
      check("t3_count", 32'(count), (i % 2 == 1) ? 1 : 2);
      check("t3_tc", 32'(tc), (i % 2 == 0) ? 1 : 0);
      check("t3_busy", 32'(busy), 1);
    end

    // Enable gating 1,0,0,1.
    cyc(0, 1, 0, 4'd4);
    cyc(1, 0, 0, 4'd0);
    cyc(0, 0, 0, 4'd0);
    cyc(0, 0, 0, 4'd0);
    check("t4_hold", 32'(count), 3);
    cyc(1, 0, 0, 4'd0);
    check("t4_count", 32'(count), 2);

    // Load priority over enable; load of zero goes idle.
    cyc(0, 1, 0, 4'd4);
    cyc(1, 1, 0, 4'd9);
    check("t5_reload", {27'd0, count, tc}, {27'd0, 4'd9, 1'b0});
    check("t5_busy", 32'(busy), 1);
    cyc(1, 1, 0, 4'd0);
    check("t5_zero", {28'd0, count}, 0);
    check("t5_zero_flags", {29'd0, tc, busy, done}, 0);

    // Maximum interval 15.
    cyc(0, 1, 0, 4'd15);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 4'd0);
    check("max_before", {27'd0, count, tc}, {27'd0, 4'd1, 1'b0});
    cyc(1, 0, 0, 4'd0);
    check("max_expire", {27'd0, count, tc}, 1);

    // Reload of 1: tc on every enabled cycle.
    cyc(0, 1, 1, 4'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 4'd0);
      check("rl1_tc", {27'd0, count, tc}, {27'd0, 4'd1, 1'b1});
    end
    cyc(0, 0, 0, 4'd0);
    check("rl1_gated", {28'd0, tc, busy, done, 1'b0}, 32'b0100);
`else
    // Prescaled one-shot: 2 counts x 4 cycles.
    cyc(0, 1, 0, 4'd2);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 0, 4'd0);
      check("t6_count", 32'(count), (i < 4) ? 2 : (i < 8) ? 1 : 0);
      check("t6_tc", 32'(tc), (i == 8) ? 1 : 0);
    end
    check("t6_done", 32'(done), 1);
    cyc(0, 1, 1, 4'd1);
    cyc(1, 0, 0, 4'd0);
    cyc(0, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 4'd0);
    check("t6_rl_tc", {27'd0, count, tc}, {27'd0, 4'd1, 1'b1});
`endif

    cyc(0, 0, 0, 4'd0);
    cyc(0, 0, 0, 4'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
